// File: rtl/spi_ctrl_pkg.sv
// Shared definitions for the SPI controller: frame geometry, field widths,
// the write encoding of the rw bit and the controller state encoding.
package spi_ctrl_pkg;

  localparam int FRAME_BITS  = 16;
  localparam int ADDR_W      = 7;
  localparam int DATA_W      = 8;
  localparam logic RW_WRITE  = 1'b1;

  // One SCLK edge per divider tick during SHIFT: two edges per frame bit.
  localparam int SHIFT_EDGES = 2 * FRAME_BITS;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_GAP
  } state_t;

endpackage

// File: rtl/spi_tick_gen.sv
// Divider tick generator for the SPI controller.
// Emits a one-cycle tick every DIV clk cycles while enable is high. The
// down-counter reloads whenever enable is low, so the first tick after
// enable rises always lands exactly DIV cycles later.
//
// Ports:
//   clk     system clock
//   rst_n   asynchronous active-low reset
//   enable  count while high, hold at reload value while low
//   tick    one-cycle pulse at terminal count
module spi_tick_gen #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  output logic tick
);

  localparam logic [7:0] RELOAD = 8'(DIV - 1);

  logic [7:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= RELOAD;
    end else if (!enable || count == 8'd0) begin
      count <= RELOAD;
    end else begin
      count <= count - 8'd1;
    end
  end

  assign tick = enable && (count == 8'd0);

endmodule

// File: rtl/spi_controller.sv
// SPI mode-0 master issuing 16-bit frames {rw, addr, wdata}, MSB first.
// A divider tick paces every phase: SETUP, each of the 32 SCLK edges in
// SHIFT, HOLD and GAP each last CLK_DIV cycles. sclk, copi, ncs and done
// are registered from the next-state decode so they never glitch.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | ncs high, waiting for start
// SETUP  | ncs low, copi = frame bit 15, sclk low
// SHIFT  | sclk toggles each tick; sample cipo on rise, advance copi on fall
// HOLD   | ncs low, sclk low, copi holds bit 0
// GAP    | ncs high, busy still high; done pulses on entry
//
// Ports:
//   clk, rst_n          system clock, async active-low reset
//   start, rw, addr,    frame request and contents, latched on accept
//   wdata
//   busy, done, rdata   status, completion pulse, last received byte
//   sclk, copi, ncs     SPI outputs to the responder
//   cipo                SPI input from the responder
module spi_controller
  import spi_ctrl_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              rw,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic              sclk,
  output logic              copi,
  output logic              ncs,
  input  logic              cipo
);

  localparam int TX_W = ADDR_W + DATA_W;
  localparam logic [4:0] LAST_EDGE = 5'(SHIFT_EDGES - 1);

  state_t state, next_state;

  logic              tick;
  logic              accept;
  logic              shift_tick;
  logic              last_edge;
  logic [TX_W-1:0]   tx;
  logic [DATA_W-1:0] rx;
  logic [4:0]        edge_cnt;
  logic              sclk_d, copi_d, ncs_d, done_d;

  assign busy       = (state != ST_IDLE);
  assign accept     = (state == ST_IDLE) && start;
  assign shift_tick = (state == ST_SHIFT) && tick;
  assign last_edge  = (edge_cnt == LAST_EDGE);

  spi_tick_gen #(.DIV(CLK_DIV)) u_tick_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (busy),
    .tick   (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      ST_IDLE:  if (start)                 next_state = ST_SETUP;
      ST_SETUP: if (tick)                  next_state = ST_SHIFT;
      ST_SHIFT: if (tick && last_edge)     next_state = ST_HOLD;
      ST_HOLD:  if (tick)                  next_state = ST_GAP;
      ST_GAP:   if (tick)                  next_state = ST_IDLE;
      default:                             next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    sclk_d = sclk;
    copi_d = copi;
    ncs_d  = !(next_state inside {ST_SETUP, ST_SHIFT, ST_HOLD});
    done_d = (state == ST_HOLD) && tick;
    if (accept) begin
      copi_d = rw;
    end
    if (shift_tick) begin
      sclk_d = ~sclk;
      // Falling edge: present the next bit, except after the final fall so
      // that copi keeps bit 0 through HOLD.
      if (sclk && !last_edge) begin
        copi_d = tx[TX_W-1];
      end
    end
    if (next_state == ST_GAP || next_state == ST_IDLE) begin
      sclk_d = 1'b0;
      copi_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk <= 1'b0;
      copi <= 1'b0;
      ncs  <= 1'b1;
      done <= 1'b0;
    end else begin
      sclk <= sclk_d;
      copi <= copi_d;
      ncs  <= ncs_d;
      done <= done_d;
    end
  end

  // tx holds the bits still to be sent after the one on copi (rw goes
  // straight to copi on accept). rx keeps only the most recent DATA_W bits
  // of the 16 shifted in: the address-phase byte falls off the top and is
  // never observable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx       <= '0;
      rx       <= '0;
      edge_cnt <= '0;
      rdata    <= '0;
    end else begin
      if (accept) begin
        tx       <= {addr, wdata};
        rx       <= '0;
        edge_cnt <= '0;
      end else if (shift_tick) begin
        edge_cnt <= edge_cnt + 5'd1;
        if (!sclk) begin
          rx <= {rx[DATA_W-2:0], cipo};
        end else if (!last_edge) begin
          tx <= {tx[TX_W-2:0], 1'b0};
        end
      end
      if (done_d) begin
        rdata <= rx;
      end
    end
  end

endmodule

// File: tb/tb_spi_controller.sv
// Directed bench for spi_controller: a vector table of single frames on a
// CLK_DIV=4 instance with a mode-0 responder model, then hand-written
// sequences for back-to-back frames (CLK_DIV=2), reset mid-frame, and a
// loopback at the maximum divider (CLK_DIV=255).
module tb_spi_controller;
  import spi_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start4, start2, start255;
  logic       rw;
  logic [6:0] addr;
  logic [7:0] wdata;
  logic       cipo4, cipo2;

  logic       busy4, done4, sclk4, copi4, ncs4;
  logic [7:0] rdata4;
  logic       busy2, done2, sclk2, copi2, ncs2;
  logic [7:0] rdata2;
  logic       busy255, done255, sclk255, copi255, ncs255;
  logic [7:0] rdata255;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  spi_controller #(.CLK_DIV(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .rw(rw), .addr(addr), .wdata(wdata),
    .busy(busy4), .done(done4), .rdata(rdata4), .sclk(sclk4), .copi(copi4),
    .ncs(ncs4), .cipo(cipo4)
  );

  spi_controller #(.CLK_DIV(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .rw(rw), .addr(addr), .wdata(wdata),
    .busy(busy2), .done(done2), .rdata(rdata2), .sclk(sclk2), .copi(copi2),
    .ncs(ncs2), .cipo(cipo2)
  );

  spi_controller #(.CLK_DIV(255)) dut255 (
    .clk(clk), .rst_n(rst_n), .start(start255), .rw(rw), .addr(addr), .wdata(wdata),
    .busy(busy255), .done(done255), .rdata(rdata255), .sclk(sclk255), .copi(copi255),
    .ncs(ncs255), .cipo(copi255)
  );

  typedef struct {
    logic        rw;
    logic [6:0]  addr;
    logic [7:0]  wdata;
    logic [15:0] resp;       // word the responder shifts out on cipo
    logic [15:0] exp_frame;  // expected copi bits, already masked
    logic [15:0] mask;       // reads: data byte on copi is don't-care
    logic [7:0]  exp_rdata;
    int          mid_start;  // cycle of an extra start pulse, -1 for none
  } vec_t;

  vec_t vecs[4];

  function automatic vec_t mk(input logic r, input logic [6:0] a, input logic [7:0] w,
                              input logic [15:0] rs, input logic [15:0] ef,
                              input logic [15:0] m, input logic [7:0] er, input int ms);
    vec_t v;
    v.rw = r; v.addr = a; v.wdata = w; v.resp = rs; v.exp_frame = ef;
    v.mask = m; v.exp_rdata = er; v.mid_start = ms;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, got, exp);
    end
  endtask

  // One frame on dut4, observed for a fixed 160-cycle window so that a
  // wrongly queued second frame would show up as extra busy/done/ncs activity.
  task automatic run4(input vec_t v, input int idx);
    logic [15:0] got = '0;
    int   busy_len = 0, done_at = -1, done_cnt = 0, rises = 0, falls = 0;
    logic prev_sclk = 1'b0, prev_ncs = 1'b1;
    cipo4 = v.resp[15];
    @(negedge clk);
    rw = v.rw; addr = v.addr; wdata = v.wdata; start4 = 1'b1;
    for (int n = 1; n <= 160; n++) begin
      @(negedge clk);
      start4 = (n == v.mid_start);
      if (n == 20) begin
        rw = ~rw; addr = ~addr; wdata = ~wdata;
      end
      if (busy4) busy_len++;
      if (done4) begin
        done_cnt++;
        if (done_at < 0) done_at = n;
      end
      if (prev_ncs && !ncs4) falls++;
      if (!prev_sclk && sclk4) begin
        got = {got[14:0], copi4};
        rises++;
        cipo4 = (rises < 16) ? v.resp[15 - rises] : 1'b0;
      end
      prev_sclk = sclk4;
      prev_ncs  = ncs4;
    end
    chk($sformatf("v%0d_frame", idx), 32'(got & v.mask), 32'(v.exp_frame));
    chk($sformatf("v%0d_sclk_pulses", idx), rises, 16);
    chk($sformatf("v%0d_busy_len", idx), busy_len, 140);
    chk($sformatf("v%0d_done_at", idx), done_at, 137);
    chk($sformatf("v%0d_done_cnt", idx), done_cnt, 1);
    chk($sformatf("v%0d_ncs_falls", idx), falls, 1);
    chk($sformatf("v%0d_rdata", idx), 32'(rdata4), 32'(v.exp_rdata));
  endtask

  initial begin
    rst_n = 1'b0;
    start4 = 1'b0; start2 = 1'b0; start255 = 1'b0;
    rw = 1'b0; addr = '0; wdata = '0;
    cipo4 = 1'b0; cipo2 = 1'b0;

    vecs[0] = mk(RW_WRITE, 7'h00, 8'hF0, 16'h0000, 16'h80F0, 16'hFFFF, 8'h00, -1);
    vecs[1] = mk(~RW_WRITE, 7'h04, 8'h00, 16'h00A5, 16'h0400, 16'hFF00, 8'hA5, 10);
    vecs[2] = mk(RW_WRITE, 7'h7F, 8'h5A, 16'h1234, 16'hFF5A, 16'hFFFF, 8'h34, -1);
    vecs[3] = mk(~RW_WRITE, 7'h2A, 8'h99, 16'hFFC3, 16'h2A00, 16'hFF00, 8'hC3, 50);

    repeat (3) @(negedge clk);
    chk("rst_ncs", 32'(ncs4), 32'd1);
    chk("rst_sclk", 32'(sclk4), 32'd0);
    chk("rst_copi", 32'(copi4), 32'd0);
    chk("rst_busy", 32'(busy4), 32'd0);
    chk("rst_done", 32'(done4), 32'd0);
    chk("rst_rdata", 32'(rdata4), 32'd0);
    chk("rst_busy2", 32'(busy2), 32'd0);
    chk("rst_ncs255", 32'(ncs255), 32'd1);
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) run4(vecs[i], i);

    // Back-to-back frames on dut2 with start held. Between frames ncs stays
    // high for the CLK_DIV GAP cycles plus the IDLE cycle that accepts start.
    begin
      logic [15:0] frame2 = '0;
      int   falls = 0, dones = 0, hi_run = 0;
      logic prev_sclk = 1'b0, prev_ncs = 1'b1;
      @(negedge clk);
      rw = 1'b1; addr = 7'h55; wdata = 8'h0F; start2 = 1'b1;
      for (int n = 0; n < 300; n++) begin
        @(negedge clk);
        if (prev_ncs && !ncs2) begin
          falls++;
          if (falls >= 2) chk($sformatf("b2b_gap%0d", falls), hi_run, 3);
          hi_run = 0;
          frame2 = '0;
          if (falls == 3) start2 = 1'b0;
        end
        if (ncs2) hi_run++;
        if (!prev_sclk && sclk2) frame2 = {frame2[14:0], copi2};
        if (done2) begin
          dones++;
          chk($sformatf("b2b_frame%0d", dones), 32'(frame2), 32'h0000D50F);
        end
        prev_sclk = sclk2;
        prev_ncs  = ncs2;
      end
      start2 = 1'b0;
      chk("b2b_done_cnt", dones, 3);
      chk("b2b_frames", falls, 3);
      chk("b2b_idle_after", 32'(busy2), 32'd0);
    end

    // Reset asserted mid-way through SHIFT, just after the 9th rising edge.
    begin
      int   rises = 0, found = 0, done_seen = 0, sclk_seen = 0, ncs_low = 0;
      logic prev_sclk = 1'b0;
      cipo4 = 1'b1;
      @(negedge clk);
      rw = 1'b1; addr = 7'h33; wdata = 8'hCC; start4 = 1'b1;
      for (int n = 0; n < 200; n++) begin
        @(negedge clk);
        start4 = 1'b0;
        if (!prev_sclk && sclk4) rises++;
        prev_sclk = sclk4;
        if (rises == 9) begin
          found = 1;
          break;
        end
      end
      chk("rst_mid_reached_bit9", found, 1);
      #1 rst_n = 1'b0;
      #1;
      chk("rst_mid_ncs", 32'(ncs4), 32'd1);
      chk("rst_mid_sclk", 32'(sclk4), 32'd0);
      chk("rst_mid_busy", 32'(busy4), 32'd0);
      chk("rst_mid_rdata", 32'(rdata4), 32'd0);
      for (int n = 0; n < 24; n++) begin
        @(negedge clk);
        if (n == 3) rst_n = 1'b1;
        if (done4) done_seen++;
        if (sclk4) sclk_seen++;
        if (!ncs4) ncs_low++;
      end
      chk("rst_mid_no_done", done_seen, 0);
      chk("rst_mid_no_sclk", sclk_seen, 0);
      chk("rst_mid_ncs_stays_high", ncs_low, 0);
      chk("rst_mid_rdata_after", 32'(rdata4), 32'd0);
      cipo4 = 1'b0;
    end

    // Loopback at the maximum divider: cipo is wired to copi, so the
    // received low byte must equal wdata.
    begin
      int busy_len = 0, done_at = -1, dones = 0;
      @(negedge clk);
      rw = 1'b1; addr = 7'h11; wdata = 8'h3C; start255 = 1'b1;
      for (int n = 1; n <= 8950; n++) begin
        @(negedge clk);
        start255 = 1'b0;
        if (busy255) busy_len++;
        if (done255) begin
          dones++;
          if (done_at < 0) done_at = n;
        end
      end
      chk("lb_busy_len", busy_len, 35 * 255);
      chk("lb_done_at", done_at, 1 + 34 * 255);
      chk("lb_done_cnt", dones, 1);
      chk("lb_rdata", 32'(rdata255), 32'h3C);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
